// File: rtl/sseg_mux_capture.sv
//------------------------------------------------------------------------------
// sseg_mux_capture : decodes a scanned 7-segment an/sseg bus into a 4-digit frame
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sseg_mux_capture #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 2**20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] an,
   input  logic [7:0] sseg,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic [3:0] dp_out,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       err
);

   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [3:0]    C_LAST  = (SETTLE >= 2) ? 4'(SETTLE - 2) : 4'd0;
   localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   // Returns {legal, value} for a 7-bit active-low segment code.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h10:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] an_idx(input logic [3:0] a);
      logic [1:0] r;
      case (a)
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   logic [3:0]    an_s1_q, an_s2_q;
   logic [7:0]    sseg_s1_q, sseg_s2_q;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    lat_an_q, lat_an_d;
   logic [7:0]    lat_sseg_q, lat_sseg_d;
   logic [3:0]    hex_q [4];
   logic [3:0]    hex_d [4];
   logic [3:0]    dp_q, dp_d;
   logic [3:0]    valid_q, valid_d;
   logic [3:0]    seen_q, seen_d;
   logic          frame_q, frame_d;
   logic          err_q, err_d;

   logic          w_one;
   logic          w_multi;
   logic          w_changed;
   logic [4:0]    w_dec;
   logic [1:0]    w_idx;
   logic [3:0]    w_seen_next;
   logic          w_cap;

   assign w_one     = (an_s2_q == 4'b1110) || (an_s2_q == 4'b1101) ||
                      (an_s2_q == 4'b1011) || (an_s2_q == 4'b0111);
   // More than one zero: clearing the lowest set bit of ~an leaves something.
   assign w_multi   = |((~an_s2_q) & ((~an_s2_q) - 4'd1));
   assign w_changed = (an_s2_q != lat_an_q) || (sseg_s2_q != lat_sseg_q);
   assign w_dec     = decode(lat_sseg_q[6:0]);
   assign w_idx     = an_idx(lat_an_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_an_d    = lat_an_q;
      lat_sseg_d  = lat_sseg_q;
      hex_d       = hex_q;
      dp_d        = dp_q;
      valid_d     = valid_q;
      seen_d      = seen_q;
      frame_d     = 1'b0;
      err_d       = 1'b0;
      w_cap       = 1'b0;
      w_seen_next = seen_q | (4'b0001 << w_idx);

      case (state_q)
         S_IDLE: begin
            if (w_one) begin
               state_d    = S_SETTLE;
               cnt_d      = 4'd0;
               lat_an_d   = an_s2_q;
               lat_sseg_d = sseg_s2_q;
            end
         end
         S_SETTLE: begin
            if (w_changed) begin
               cnt_d      = 4'd0;
               lat_an_d   = an_s2_q;
               lat_sseg_d = sseg_s2_q;
               if (!w_one) begin
                  state_d = S_IDLE;
                  err_d   = w_multi;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q >= C_LAST) begin
                  state_d = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            state_d = S_HOLD;
            w_cap   = 1'b1;
            if (w_dec[4]) begin
               hex_d[w_idx]   = w_dec[3:0];
               dp_d[w_idx]    = ~lat_sseg_q[7];
               valid_d[w_idx] = 1'b1;
               if (w_seen_next == 4'b1111) begin
                  frame_d = 1'b1;
                  seen_d  = 4'b0000;
               end else begin
                  seen_d  = w_seen_next;
               end
            end else begin
               err_d = 1'b1;
            end
         end
         S_HOLD: begin
            // Segment-only changes are deliberately ignored until the anode moves.
            if (an_s2_q != lat_an_q) begin
               if (w_one) begin
                  state_d    = S_SETTLE;
                  cnt_d      = 4'd0;
                  lat_an_d   = an_s2_q;
                  lat_sseg_d = sseg_s2_q;
               end else if (an_s2_q == 4'b1111) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A capture in the expiry cycle takes priority over the timeout clear.
      if (w_cap) begin
         tcnt_d = '0;
      end else if (tcnt_q != C_TLAST) begin
         tcnt_d = tcnt_q + TW'(1);
      end else begin
         tcnt_d  = tcnt_q;
         valid_d = 4'b0000;
         seen_d  = 4'b0000;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an_s1_q    <= 4'hF;
         an_s2_q    <= 4'hF;
         sseg_s1_q  <= 8'hFF;
         sseg_s2_q  <= 8'hFF;
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         tcnt_q     <= '0;
         lat_an_q   <= 4'hF;
         lat_sseg_q <= 8'hFF;
         hex_q      <= '{default: 4'h0};
         dp_q       <= 4'b0000;
         valid_q    <= 4'b0000;
         seen_q     <= 4'b0000;
         frame_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         an_s1_q    <= an;
         an_s2_q    <= an_s1_q;
         sseg_s1_q  <= sseg;
         sseg_s2_q  <= sseg_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         lat_an_q   <= lat_an_d;
         lat_sseg_q <= lat_sseg_d;
         hex_q      <= hex_d;
         dp_q       <= dp_d;
         valid_q    <= valid_d;
         seen_q     <= seen_d;
         frame_q    <= frame_d;
         err_q      <= err_d;
      end
   end

   assign hex0        = hex_q[0];
   assign hex1        = hex_q[1];
   assign hex2        = hex_q[2];
   assign hex3        = hex_q[3];
   assign dp_out      = dp_q;
   assign digit_valid = valid_q;
   assign frame_done  = frame_q;
   assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_mux_capture.sv
//------------------------------------------------------------------------------
// tb_sseg_mux_capture : directed scoreboard bench for sseg_mux_capture
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sseg_mux_capture;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 300;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] an = 4'hF;
   logic [7:0] sseg = 8'hFF;
   logic [3:0] hex3, hex2, hex1, hex0;
   logic [3:0] dp_out;
   logic [3:0] digit_valid;
   logic       frame_done;
   logic       err;

   sseg_mux_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .an          (an),
      .sseg        (sseg),
      .hex3        (hex3),
      .hex2        (hex2),
      .hex1        (hex1),
      .hex0        (hex0),
      .dp_out      (dp_out),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int frame_cnt = 0;
   int err_cnt = 0;

   always @(posedge clk) begin
      if (frame_done === 1'b1) frame_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   typedef struct {
      int         idx;
      logic [3:0] hex;
      logic       dp;
   } exp_t;

   exp_t sb[$];

   logic [7:0] seg_tab [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

   function automatic logic [3:0] hex_of(input int i);
      case (i)
         0:       return hex0;
         1:       return hex1;
         2:       return hex2;
         default: return hex3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [7:0] s);
      @(negedge clk);
      an   = a;
      sseg = s;
   endtask

   task automatic digit(input int idx, input logic [7:0] s, input logic [3:0] h,
                        input logic d, input int hold);
      exp_t e;
      logic [3:0] a;
      a = 4'hF;
      a[idx] = 1'b0;
      drive(a, s);
      e.idx = idx;
      e.hex = h;
      e.dp  = d;
      sb.push_back(e);
      repeat (hold) @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("hex%0d", e.idx), hex_of(e.idx), e.hex);
      chk($sformatf("dp%0d", e.idx), dp_out[e.idx], e.dp);
      chk($sformatf("valid%0d", e.idx), digit_valid[e.idx], 1);
   endtask

   initial begin
      exp_t e;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      chk("rst_dp", dp_out, 4'b0000);
      chk("rst_valid", digit_valid, 4'b0000);
      chk("rst_frame", frame_done, 1'b0);
      chk("rst_err", err, 1'b0);
      reset_n = 1'b1;

      // Illegal segment code: one err, nothing captured
      drive(4'b1110, 8'h7F);
      repeat (30) @(negedge clk);
      chk("illegal_err", err_cnt, 1);
      chk("illegal_valid", digit_valid, 4'b0000);
      chk("illegal_frame", frame_cnt, 0);

      // Two anodes low after HOLD: one err, outputs untouched
      drive(4'b1100, 8'hC0);
      repeat (20) @(negedge clk);
      chk("multi_err", err_cnt, 2);
      chk("multi_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      chk("multi_valid", digit_valid, 4'b0000);
      drive(4'b1111, 8'hFF);
      repeat (5) @(negedge clk);

      // Two full scan rounds of 0,1,2,3
      for (int r = 0; r < 2; r++) begin
         for (int d = 0; d < 4; d++) begin
            digit(d, seg_tab[d], 4'(d), 1'b0, 64);
         end
         chk($sformatf("frames_round%0d", r), frame_cnt, r + 1);
      end
      chk("scan_valid", digit_valid, 4'b1111);
      chk("scan_hex", {hex3, hex2, hex1, hex0}, 16'h3210);
      chk("scan_dp", dp_out, 4'b0000);
      chk("scan_err", err_cnt, 2);

      // Decimal point on digit 1
      digit(1, 8'h79, 4'h1, 1'b1, 64);
      chk("dp_vec", dp_out, 4'b0010);
      chk("dp_frames", frame_cnt, 2);

      // Anode toggling faster than the settle window
      for (int i = 0; i < 20; i++) begin
         drive((i % 2 == 1) ? 4'b1101 : 4'b1110, 8'h86);
         repeat (2) @(negedge clk);
      end
      drive(4'b1111, 8'hFF);
      repeat (10) @(negedge clk);
      chk("toggle_hex", {hex3, hex2, hex1, hex0}, 16'h3210);
      chk("toggle_dp", dp_out, 4'b0010);
      chk("toggle_frames", frame_cnt, 2);
      chk("toggle_err", err_cnt, 2);
      chk("toggle_valid", digit_valid, 4'b1111);

      // Timeout clears valid, keeps values
      repeat (TIMEOUT + 20) @(negedge clk);
      chk("tmo_valid", digit_valid, 4'b0000);
      chk("tmo_hex", {hex3, hex2, hex1, hex0}, 16'h3210);
      chk("tmo_dp", dp_out, 4'b0010);

      // Reset asserted mid-SETTLE
      drive(4'b1110, 8'hC0);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      an      = 4'hF;
      sseg    = 8'hFF;
      #1;
      chk("mid_rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      chk("mid_rst_dp", dp_out, 4'b0000);
      chk("mid_rst_valid", digit_valid, 4'b0000);
      chk("mid_rst_frame", frame_done, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Edge-to-output latency: 2 sync + SETTLE + 1
      drive(4'b1101, 8'hA4);
      e.idx = 1;
      e.hex = 4'h2;
      e.dp  = 1'b0;
      sb.push_back(e);
      repeat (2 + SETTLE) @(negedge clk);
      chk("lat_early_hex1", hex1, 4'h0);
      chk("lat_early_valid", digit_valid, 4'b0000);
      @(negedge clk);
      e = sb.pop_front();
      chk("lat_hex1", hex_of(e.idx), e.hex);
      chk("lat_dp1", dp_out[e.idx], e.dp);
      chk("lat_valid", digit_valid, 4'b0010);
      chk("end_err", err_cnt, 2);
      chk("end_frames", frame_cnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
